// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: three-requester round-robin front end for a single SPI master.
// One transaction runs at a time: SETUP, then CS held for XFER_CYCLES, then CAPTURE, then an idle gap.
module spi_txn_arbiter #(
  parameter int unsigned XFER_CYCLES = 18,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [5:0]  req_cs,
  input  logic [5:0]  req_rw,
  input  logic [23:0] req_wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic        err,
  output logic [7:0]  rdata,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [1:0]  cfg_mode,
  output logic        busy,
  output logic [1:0]  spi_CS,
  output logic [1:0]  spi_RW,
  output logic [1:0]  spi_MODE,
  output logic [7:0]  spi_data_in,
  input  logic [7:0]  spi_data_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    XFER    = 3'd2,
    CAPTURE = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  last_gnt_q;
  logic [1:0]  owner_q;
  logic [1:0]  cs_lat_q;
  logic [1:0]  rw_lat_q;
  logic [1:0]  mode_lat_q;
  logic [2:0]  gnt_q;
  logic [2:0]  done_q;
  logic        err_q;
  logic [7:0]  rdata_q;
  logic [1:0]  spi_cs_q;
  logic [1:0]  spi_rw_q;
  logic [7:0]  spi_din_q;
  logic [1:0]  mode_q [0:3];

  logic        pick_valid;
  logic [1:0]  pick;
  logic [1:0]  cand;
  logic [1:0]  pick_cs;
  logic [1:0]  pick_rw;
  logic [7:0]  pick_wd;
  logic [1:0]  mode_fwd;

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Round-robin pick: first requesting index after last_gnt_q, wrapping 0,1,2.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    cand       = last_gnt_q;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  assign pick_cs = req_cs[{pick, 1'b0} +: 2];
  assign pick_rw = req_rw[{pick, 1'b0} +: 2];
  assign pick_wd = req_wdata[{pick, 3'b000} +: 8];

  // A cfg write landing in the SETUP cycle for the active slave is forwarded so it wins.
  assign mode_fwd = (cfg_we && (cfg_sel == cs_lat_q)) ? cfg_mode : mode_q[cs_lat_q];

  // Per-slave SPI mode registers; entry 0 is never written and reads as 00.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 4; i++) mode_q[i] <= '0;
    end else if (cfg_we && (cfg_sel != 2'd0)) begin
      mode_q[cfg_sel] <= cfg_mode;
    end
  end

  // Transaction FSM with registered pulses and SPI drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 2'd2;
      owner_q    <= '0;
      cs_lat_q   <= '0;
      rw_lat_q   <= '0;
      mode_lat_q <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      spi_cs_q   <= '0;
      spi_rw_q   <= '0;
      spi_din_q  <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q      <= onehot(pick);
            last_gnt_q <= pick;
            owner_q    <= pick;
            cs_lat_q   <= pick_cs;
            rw_lat_q   <= pick_rw;
            if ((pick_cs == 2'b00) || (pick_rw == 2'b00)) begin
              err_q <= 1'b1;
            end else begin
              spi_rw_q  <= pick_rw;
              spi_din_q <= pick_wd;
              state_q   <= SETUP;
            end
          end
        end
        SETUP: begin
          mode_lat_q <= mode_fwd;
          spi_cs_q   <= cs_lat_q;
          cnt_q      <= 8'(XFER_CYCLES - 1);
          state_q    <= XFER;
        end
        XFER: begin
          if (cnt_q == '0) begin
            spi_cs_q <= '0;
            state_q  <= CAPTURE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        CAPTURE: begin
          done_q <= onehot(owner_q);
          if (rw_lat_q != 2'b01) rdata_q <= spi_data_out;
          // The mandatory IDLE cycle before arbitration counts as the last gap cycle.
          if (GAP_CYCLES > 1) begin
            cnt_q   <= 8'(GAP_CYCLES - 2);
            state_q <= GAP;
          end else begin
            state_q <= IDLE;
          end
        end
        GAP: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q != IDLE);
  assign spi_CS      = spi_cs_q;
  assign spi_RW      = spi_rw_q;
  assign spi_data_in = spi_din_q;
  assign spi_MODE    = (state_q == SETUP) ? mode_fwd : mode_lat_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: a table of whole transactions plus a mid-transfer reset sequence.
module tb_spi_txn_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [5:0]  req_cs;
  logic [5:0]  req_rw;
  logic [23:0] req_wdata;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        err;
  logic [7:0]  rdata;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [1:0]  cfg_mode;
  logic        busy;
  logic [1:0]  spi_CS;
  logic [1:0]  spi_RW;
  logic [1:0]  spi_MODE;
  logic [7:0]  spi_data_in;
  logic [7:0]  spi_data_out;

  int n_vec = 0;
  int n_bad = 0;

  spi_txn_arbiter #(.XFER_CYCLES(18), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_cs(req_cs), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .busy(busy),
    .spi_CS(spi_CS), .spi_RW(spi_RW), .spi_MODE(spi_MODE),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [5:0]  cs;
    logic [5:0]  rw;
    logic [23:0] wd;
    logic [7:0]  sdo;
    logic        sw;     // cfg write to the active slave during SETUP
    logic [1:0]  smode;
    logic        mw;     // cfg write to the active slave during XFER
    logic [1:0]  mmode;
    logic [2:0]  egnt;
    logic        eerr;
    logic [1:0]  ecs;
    logic [1:0]  erw;
    logic [7:0]  edin;
    logic [1:0]  emode;
    logic [7:0]  erd;
  } vec_t;

  vec_t tbl [9];

  localparam logic [5:0]  CS_D = 6'b111001;  // r2->slave3, r1->slave2, r0->slave1
  localparam logic [5:0]  RW_D = 6'b011011;  // r2 write, r1 read, r0 exchange
  localparam logic [23:0] WD_D = 24'h2211A5;

  function automatic vec_t mk(input logic [2:0] rq, input logic [5:0] cs, input logic [5:0] rw,
                              input logic [23:0] wd, input logic [7:0] sdo,
                              input logic sw, input logic [1:0] smode,
                              input logic mw, input logic [1:0] mmode,
                              input logic [2:0] egnt, input logic eerr, input logic [1:0] ecs,
                              input logic [1:0] erw, input logic [7:0] edin,
                              input logic [1:0] emode, input logic [7:0] erd);
    vec_t v;
    v.req = rq; v.cs = cs; v.rw = rw; v.wd = wd; v.sdo = sdo;
    v.sw = sw; v.smode = smode; v.mw = mw; v.mmode = mmode;
    v.egnt = egnt; v.eerr = eerr; v.ecs = ecs; v.erw = erw;
    v.edin = edin; v.emode = emode; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input int idx);
    vec_t v;
    bit   got;
    int   cs_hi;
    bit   stab;
    bit   early;
    logic [1:0] cap_cs;
    v = tbl[idx];
    req = v.req; req_cs = v.cs; req_rw = v.rw; req_wdata = v.wd; spi_data_out = v.sdo;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (gnt != 3'b000) got = 1;
    end
    if (!got) begin
      req = '0;
      chk($sformatf("v%0d_gnt_timeout", idx), 32'd0, 32'd1);
      return;
    end
    chk($sformatf("v%0d_gnt", idx), gnt, v.egnt);
    chk($sformatf("v%0d_err", idx), err, v.eerr);
    req = '0;
    if (v.eerr) begin
      chk($sformatf("v%0d_err_cs", idx), spi_CS, 2'b00);
      chk($sformatf("v%0d_err_busy", idx), busy, 1'b0);
      stab = 1;
      for (int n = 0; n < 3; n++) begin
        @(negedge clk);
        if (done != 0 || spi_CS != 0 || err != 0 || gnt != 0 || busy != 0) stab = 0;
      end
      chk($sformatf("v%0d_err_quiet", idx), stab, 1'b1);
      return;
    end
    if (v.sw) begin
      cfg_we = 1'b1; cfg_sel = v.ecs; cfg_mode = v.smode;
      #1;
    end
    chk($sformatf("v%0d_setup_cs", idx), spi_CS, 2'b00);
    chk($sformatf("v%0d_setup_rw", idx), spi_RW, v.erw);
    chk($sformatf("v%0d_setup_din", idx), spi_data_in, v.edin);
    chk($sformatf("v%0d_setup_mode", idx), spi_MODE, v.emode);
    chk($sformatf("v%0d_setup_busy", idx), busy, 1'b1);
    cs_hi = 0; stab = 1; early = 0; cap_cs = 2'b11;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      if (spi_CS == v.ecs) cs_hi++;
      else if (spi_CS != 2'b00) stab = 0;
      if (n <= 18 && (spi_MODE != v.emode || spi_RW != v.erw || spi_data_in != v.edin || !busy))
        stab = 0;
      if (done != 3'b000) early = 1;
      if (n == 19) cap_cs = spi_CS;
      if (n == 3 && v.mw) begin
        cfg_we = 1'b1; cfg_sel = v.ecs; cfg_mode = v.mmode;
      end
    end
    chk($sformatf("v%0d_cs_cycles", idx), cs_hi, 18);
    chk($sformatf("v%0d_xfer_stable", idx), stab, 1'b1);
    chk($sformatf("v%0d_no_early_done", idx), early, 1'b0);
    chk($sformatf("v%0d_capture_cs", idx), cap_cs, 2'b00);
    @(negedge clk);
    chk($sformatf("v%0d_done", idx), done, v.egnt);
    chk($sformatf("v%0d_rdata", idx), rdata, v.erd);
    @(negedge clk);
    chk($sformatf("v%0d_done_clear", idx), done, 3'b000);
    chk($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
  endtask

  initial begin
    tbl[0] = mk(3'b001, CS_D, RW_D, WD_D, 8'h3C, 0, 2'b00, 0, 2'b00, 3'b001, 0, 2'b01, 2'b11, 8'hA5, 2'b00, 8'h3C);
    tbl[1] = mk(3'b111, CS_D, RW_D, WD_D, 8'h5A, 0, 2'b00, 1, 2'b01, 3'b010, 0, 2'b10, 2'b10, 8'h11, 2'b11, 8'h5A);
    tbl[2] = mk(3'b111, CS_D, RW_D, WD_D, 8'h77, 1, 2'b10, 0, 2'b00, 3'b100, 0, 2'b11, 2'b01, 8'h22, 2'b10, 8'h5A);
    tbl[3] = mk(3'b111, CS_D, RW_D, WD_D, 8'hC3, 0, 2'b00, 0, 2'b00, 3'b001, 0, 2'b01, 2'b11, 8'hA5, 2'b00, 8'hC3);
    tbl[4] = mk(3'b001, 6'b111000, RW_D, WD_D, 8'h00, 0, 2'b00, 0, 2'b00, 3'b001, 1, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00);
    tbl[5] = mk(3'b111, CS_D, RW_D, WD_D, 8'h0F, 0, 2'b00, 0, 2'b00, 3'b010, 0, 2'b10, 2'b10, 8'h11, 2'b01, 8'h0F);
    tbl[6] = mk(3'b010, CS_D, 6'b010011, WD_D, 8'h00, 0, 2'b00, 0, 2'b00, 3'b010, 1, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00);
    tbl[7] = mk(3'b101, CS_D, RW_D, WD_D, 8'h81, 0, 2'b00, 0, 2'b00, 3'b100, 0, 2'b11, 2'b01, 8'h22, 2'b10, 8'h0F);
    tbl[8] = mk(3'b011, 6'b111010, 6'b011010, 24'h22115E, 8'h99, 0, 2'b00, 0, 2'b00, 3'b001, 0, 2'b10, 2'b10, 8'h5E, 2'b00, 8'h99);

    reset = 1'b0; req = '0; req_cs = '0; req_rw = '0; req_wdata = '0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_mode = '0; spi_data_out = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt_done_err", {gnt, done, err}, 7'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_spi", {spi_CS, spi_RW, spi_MODE, spi_data_in}, 14'd0);
    chk("rst_rdata", rdata, 8'h00);
    reset = 1'b1;

    // Mode registers: slave2=11, slave3=01; a write to index 0 is ignored.
    @(negedge clk); cfg_we = 1'b1; cfg_sel = 2'd2; cfg_mode = 2'b11;
    @(negedge clk); cfg_sel = 2'd3; cfg_mode = 2'b01;
    @(negedge clk); cfg_sel = 2'd0; cfg_mode = 2'b10;
    @(negedge clk); cfg_we = 1'b0;
    chk("cfg_idle_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) apply(i);

    // Reset during XFER cycle 5 must drop CS and busy at once.
    req = 3'b001; req_cs = CS_D; req_rw = RW_D; req_wdata = WD_D; spi_data_out = 8'h44;
    begin
      bit got;
      got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        if (gnt != 3'b000) got = 1;
      end
      chk("rstx_gnt", gnt, 3'b001);
    end
    req = '0;
    repeat (5) @(negedge clk);
    chk("rstx_cs_before", spi_CS, 2'b01);
    #2 reset = 1'b0;
    #1;
    chk("rstx_cs", spi_CS, 2'b00);
    chk("rstx_busy", busy, 1'b0);
    chk("rstx_outs", {gnt, done, err, rdata, spi_RW, spi_MODE, spi_data_in}, 31'd0);
    repeat (2) @(negedge clk);
    chk("rstx_no_done", {done, busy}, 4'd0);
    reset = 1'b1;
    @(negedge clk);
    apply(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
